// File: rtl/uart_nec_cmd_ctrl.sv
// Parses 4-byte UART frames (HDR, addr, cmd, addr^cmd) into a small command queue and dispatches them to an NEC transmitter.
// Latency: chk strobe at N -> nec_start at N+2 on an idle path; a full queue drops the frame with an overflow pulse.
module uart_nec_cmd_ctrl #(
    parameter int         TIMEOUT_CYC = 125000,
    parameter logic [7:0] HDR_BYTE    = 8'hAA,
    parameter int         FIFO_DEPTH  = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_valid,
    input  logic                          nec_busy,
    output logic                          nec_start,
    output logic [7:0]                    nec_addr,
    output logic [7:0]                    nec_cmd,
    output logic                          frame_err,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   q_level
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {P_HDR, P_ADDR, P_CMD, P_CHK} p_state_t;
    typedef enum logic [1:0] {D_IDLE, D_ACK, D_RUN} d_state_t;

    p_state_t        p_state, p_next;
    d_state_t        d_state, d_next;
    logic [7:0]      addr_r, cmd_r;
    logic [TW-1:0]   tmo_cnt, tmo_next;
    logic [3:0]      ack_cnt, ack_next;
    logic            chk_ok, chk_bad, tmo_fire, ack_err;
    logic            push, pop, q_full, q_empty;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [LW-1:0]   q_cnt;
    logic [15:0]     mem [FIFO_DEPTH];

    assign q_full  = (q_cnt == LW'(FIFO_DEPTH));
    assign q_empty = (q_cnt == '0);
    assign push    = chk_ok && !q_full;
    assign q_level = q_cnt;

    // A byte arriving in the expiry cycle wins over the timeout.
    always_comb begin
        p_next   = p_state;
        tmo_next = tmo_cnt;
        chk_ok   = 1'b0;
        chk_bad  = 1'b0;
        tmo_fire = 1'b0;
        if (rx_valid) begin
            tmo_next = '0;
            case (p_state)
                P_HDR:   if (rx_data == HDR_BYTE) p_next = P_ADDR;
                P_ADDR:  p_next = P_CMD;
                P_CMD:   p_next = P_CHK;
                default: begin
                    p_next = P_HDR;
                    if (rx_data == (addr_r ^ cmd_r)) chk_ok  = 1'b1;
                    else                             chk_bad = 1'b1;
                end
            endcase
        end else if (p_state != P_HDR) begin
            if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
                tmo_fire = 1'b1;
                p_next   = P_HDR;
                tmo_next = '0;
            end else begin
                tmo_next = tmo_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        d_next   = d_state;
        ack_next = ack_cnt;
        pop      = 1'b0;
        ack_err  = 1'b0;
        case (d_state)
            D_IDLE: if (!q_empty && !nec_busy) begin
                pop      = 1'b1;
                ack_next = '0;
                d_next   = D_ACK;
            end
            D_ACK: begin
                if (nec_busy) begin
                    d_next = D_RUN;
                end else if (ack_cnt == 4'd15) begin
                    ack_err = 1'b1;
                    d_next  = D_IDLE;
                end else begin
                    ack_next = ack_cnt + 4'd1;
                end
            end
            D_RUN:   if (!nec_busy) d_next = D_IDLE;
            default: d_next = D_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            p_state   <= P_HDR;
            d_state   <= D_IDLE;
            addr_r    <= 8'h00;
            cmd_r     <= 8'h00;
            tmo_cnt   <= '0;
            ack_cnt   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            q_cnt     <= '0;
            nec_start <= 1'b0;
            nec_addr  <= 8'h00;
            nec_cmd   <= 8'h00;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            p_state   <= p_next;
            d_state   <= d_next;
            tmo_cnt   <= tmo_next;
            ack_cnt   <= ack_next;
            if (rx_valid && p_state == P_ADDR) addr_r <= rx_data;
            if (rx_valid && p_state == P_CMD)  cmd_r  <= rx_data;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                nec_addr <= mem[rd_ptr][15:8];
                nec_cmd  <= mem[rd_ptr][7:0];
            end
            q_cnt     <= q_cnt + LW'(push) - LW'(pop);
            nec_start <= pop;
            frame_err <= chk_bad || tmo_fire || ack_err;
            overflow  <= chk_ok && q_full;
        end
    end

    // Storage needs no reset: occupancy is tracked by q_cnt alone.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= {addr_r, cmd_r};
    end
endmodule

// File: doc/uart_nec_cmd_ctrl.md
UART_NEC_CMD_CTRL -- requirements
Module: uart_nec_cmd_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 125000: inter-byte timeout in clock cycles (10 ms at 12.5 MHz).
REQ-002 Parameter HDR_BYTE, default 8'hAA: frame header value.
REQ-003 Parameter FIFO_DEPTH, default 4: command queue entries (power of two, 2..16).
REQ-004 clock  in  1  single system clock, all logic on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 rx_data  in  8  received UART byte, valid only with rx_valid.
REQ-007 rx_valid  in  1  one-cycle strobe, new byte on rx_data.
REQ-008 nec_busy  in  1  NEC transmitter busy, high for whole frame transmission.
REQ-009 nec_start  out  1  one-cycle request to start NEC frame.
REQ-010 nec_addr  out  8  NEC address, stable from nec_start until nec_busy falls.
REQ-011 nec_cmd  out  8  NEC command, same stability as nec_addr.
REQ-012 frame_err  out  1  one-cycle pulse: checksum error or timeout.
REQ-013 overflow  out  1  one-cycle pulse: valid frame dropped, queue full.
REQ-014 q_level  out  clog2(FIFO_DEPTH)+1  current queue occupancy.

Function
REQ-015 Frame format SHALL be 4 bytes: HDR_BYTE, addr, cmd, chk; valid when chk == addr XOR cmd.
REQ-016 Parser FSM SHALL have states P_HDR, P_ADDR, P_CMD, P_CHK; each advance occurs only on rx_valid.
REQ-017 P_HDR: byte == HDR_BYTE -> P_ADDR; any other byte ignored silently, remain P_HDR.
REQ-018 P_ADDR latches addr -> P_CMD; P_CMD latches cmd -> P_CHK; P_CHK evaluates checksum -> P_HDR.
REQ-019 Checksum match in P_CHK SHALL push {addr,cmd} into queue in the cycle after the chk strobe.
REQ-020 Checksum mismatch SHALL pulse frame_err one cycle after the chk strobe; nothing pushed.
REQ-021 Push when queue full SHALL drop frame, pulse overflow one cycle; queue contents unchanged.
REQ-022 Timeout counter SHALL clear on every rx_valid and count only while parser not in P_HDR.
REQ-023 Counter reaching TIMEOUT_CYC-1 SHALL force P_HDR, pulse frame_err, clear counter.
REQ-024 rx_valid in same cycle as timeout expiry: byte processed normally, no timeout.
REQ-025 Dispatcher FSM SHALL have states D_IDLE, D_ACK, D_RUN.
REQ-026 D_IDLE with queue non-empty and nec_busy low: pop head to nec_addr/nec_cmd, pulse nec_start, -> D_ACK.
REQ-027 D_ACK: nec_busy high -> D_RUN; if nec_busy not high within 16 cycles, pulse frame_err -> D_IDLE.
REQ-028 D_RUN: nec_busy low -> D_IDLE; next nec_start no earlier than one cycle after.
REQ-029 Latency: empty queue, nec_busy low, valid chk strobe at cycle N -> nec_start at cycle N+2.
REQ-030 Simultaneous push and pop SHALL both take effect; q_level unchanged.
REQ-031 Queue SHALL be FIFO order; pointers wrap modulo FIFO_DEPTH.
REQ-032 nec_start, frame_err, overflow SHALL never be high two consecutive cycles from one event.

Reset
REQ-033 reset low SHALL immediately force: parser P_HDR, dispatcher D_IDLE, queue empty, counters zero.
REQ-034 Reset values: nec_start 0, nec_addr 8'h00, nec_cmd 8'h00, frame_err 0, overflow 0, q_level 0.
REQ-035 Reset mid-frame or mid-transmission SHALL discard partial frame and queue; no output pulse after release.

Verification
REQ-036 Bytes AA,12,34,26 with nec_busy low -> nec_start two cycles after last strobe, nec_addr=12, nec_cmd=34.
REQ-037 Bytes AA,12,34,27 -> one frame_err pulse, no nec_start, q_level stays 0.
REQ-038 Bytes 55,AA,01,02,03 -> 55 ignored, frame accepted, nec_addr=01, nec_cmd=02.
REQ-039 Bytes AA,12 then idle TIMEOUT_CYC cycles -> frame_err pulse; next AA,05,06,03 accepted.
REQ-040 nec_busy held high, five valid frames -> q_level=4, one overflow on fifth; release busy -> four nec_start in arrival order.
REQ-041 Assert reset during D_RUN with q_level=2 -> all outputs reset values, q_level=0, no nec_start after release.
